// File: rtl/swap_checker.sv
// swap_checker: watches the a/b pair coming out of the two-bit swap stage and
// checks that each cycle's pair is the previous pair exchanged. Keeps saturating
// good-swap / mismatch counters, a sticky error flag, a terminal FAIL state at a
// mismatch threshold, and serves counter snapshots over a req/valid/ack handshake.
module swap_checker #(
    parameter int CNT_W      = 16,
    parameter int ERR_W      = 8,
    parameter int ERR_THRESH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             a_i,
    input  logic             b_i,
    output logic [CNT_W-1:0] swap_cnt,
    output logic [ERR_W-1:0] err_cnt,
    output logic             err_flag,
    output logic             fail,
    output logic [1:0]       state_o,
    input  logic             rpt_req,
    output logic             rpt_valid,
    input  logic             rpt_ack,
    output logic [CNT_W-1:0] rpt_swap,
    output logic [ERR_W-1:0] rpt_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRIME = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_FAIL  = 2'd3;

    localparam logic [CNT_W-1:0] SWAP_MAX = '1;
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;
    localparam logic [CNT_W-1:0] SWAP_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W:0]   ERR_ONE  = {{ERR_W{1'b0}}, 1'b1};
    localparam logic [ERR_W:0]   THRESH   = ERR_THRESH[ERR_W:0];

    logic [1:0]     state;
    logic           prev_a, prev_b;
    logic           match;
    logic [ERR_W:0] err_next;   // one bit wider so the threshold test never wraps

    // A good swap means today's pair is yesterday's pair exchanged; a constant
    // equal pair (1,1 or 0,0) therefore also qualifies.
    assign match    = (a_i == prev_b) && (b_i == prev_a);
    assign err_next = {1'b0, err_cnt} + ERR_ONE;
    assign fail     = (state == S_FAIL);
    assign state_o  = state;

    // Checker state machine: prime on the first enabled edge, then compare every
    // enabled edge; FAIL is terminal until clr/rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            prev_a   <= 1'b0;
            prev_b   <= 1'b0;
            swap_cnt <= '0;
            err_cnt  <= '0;
            err_flag <= 1'b0;
        end else if (clr) begin
            state    <= S_IDLE;
            prev_a   <= 1'b0;
            prev_b   <= 1'b0;
            swap_cnt <= '0;
            err_cnt  <= '0;
            err_flag <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en) state <= S_PRIME;
                end
                S_PRIME: begin
                    if (en) begin
                        prev_a <= a_i;
                        prev_b <= b_i;
                        state  <= S_CHECK;
                    end else begin
                        state  <= S_IDLE;
                    end
                end
                S_CHECK: begin
                    if (!en) begin
                        state <= S_IDLE;
                    end else begin
                        prev_a <= a_i;
                        prev_b <= b_i;
                        if (match) begin
                            if (swap_cnt != SWAP_MAX) swap_cnt <= swap_cnt + SWAP_ONE;
                        end else begin
                            if (err_cnt != ERR_MAX) err_cnt <= err_next[ERR_W-1:0];
                            err_flag <= 1'b1;
                            if (err_next >= THRESH) state <= S_FAIL;
                        end
                    end
                end
                default: ;  // S_FAIL: everything frozen
            endcase
        end
    end

    // Snapshot handshake: capture pre-update counters on request, hold until
    // acked; the ack edge drops valid so back-to-back reports get an idle cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_valid <= 1'b0;
            rpt_swap  <= '0;
            rpt_err   <= '0;
        end else if (clr) begin
            rpt_valid <= 1'b0;
            rpt_swap  <= '0;
            rpt_err   <= '0;
        end else if (rpt_valid) begin
            if (rpt_ack) rpt_valid <= 1'b0;
        end else if (rpt_req) begin
            rpt_valid <= 1'b1;
            rpt_swap  <= swap_cnt;
            rpt_err   <= err_cnt;
        end
    end

endmodule

// File: tb/tb_swap_checker.sv
// Testbench for swap_checker: a behavioural reference model computes the
// expected outputs for every driven edge and pushes them to a scoreboard queue;
// each test task pops and compares after the edge, plus fixed-value checks.
module tb_swap_checker;

    typedef struct packed {
        logic [1:0]  st;
        logic [15:0] sw;
        logic [7:0]  er;
        logic        fl;
        logic        fa;
        logic        rv;
        logic [15:0] rs;
        logic [7:0]  re;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0, clr = 1'b0, a_i = 1'b0, b_i = 1'b0;
    logic        rpt_req = 1'b0, rpt_ack = 1'b0;
    logic [15:0] swap_cnt, rpt_swap;
    logic [7:0]  err_cnt, rpt_err;
    logic        err_flag, fail, rpt_valid;
    logic [1:0]  state_o;

    // Narrow-counter instance for the saturation boundary.
    logic        en4 = 1'b0, a4 = 1'b0, b4 = 1'b0, clr4 = 1'b0, req4 = 1'b0, ack4 = 1'b0;
    logic [3:0]  swap4, rswap4;
    logic [7:0]  err4, rerr4;
    logic        flag4, fail4, rv4;
    logic [1:0]  st4;

    int tests = 0;
    int fails = 0;
    snap_t sbq[$];
    snap_t exp_s, obs;
    logic  ph;

    // reference model state
    logic [1:0]  m_st;
    logic        m_pa, m_pb, m_fl, m_rv;
    logic [15:0] m_sw, m_rs;
    logic [7:0]  m_er, m_re;

    always #5 clk = ~clk;

    swap_checker #(.CNT_W(16), .ERR_W(8), .ERR_THRESH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .a_i(a_i), .b_i(b_i),
        .swap_cnt(swap_cnt), .err_cnt(err_cnt), .err_flag(err_flag), .fail(fail),
        .state_o(state_o), .rpt_req(rpt_req), .rpt_valid(rpt_valid), .rpt_ack(rpt_ack),
        .rpt_swap(rpt_swap), .rpt_err(rpt_err)
    );

    swap_checker #(.CNT_W(4), .ERR_W(8), .ERR_THRESH(4)) dut4 (
        .clk(clk), .rst(rst), .en(en4), .clr(clr4), .a_i(a4), .b_i(b4),
        .swap_cnt(swap4), .err_cnt(err4), .err_flag(flag4), .fail(fail4),
        .state_o(st4), .rpt_req(req4), .rpt_valid(rv4), .rpt_ack(ack4),
        .rpt_swap(rswap4), .rpt_err(rerr4)
    );

    assign obs = '{st: state_o, sw: swap_cnt, er: err_cnt, fl: err_flag, fa: fail,
                   rv: rpt_valid, rs: rpt_swap, re: rpt_err};

    task automatic model_reset();
        m_st = 2'd0; m_pa = 1'b0; m_pb = 1'b0; m_fl = 1'b0; m_rv = 1'b0;
        m_sw = '0; m_er = '0; m_rs = '0; m_re = '0;
    endtask

    // Drive one edge's inputs, advance the model, queue the expectation,
    // then step to just after the edge.
    task automatic drive(input logic e, input logic a, input logic b,
                         input logic c, input logic rq, input logic ak);
        en = e; a_i = a; b_i = b; clr = c; rpt_req = rq; rpt_ack = ak;
        if (c) begin
            model_reset();
        end else begin
            if (m_rv) begin
                if (ak) m_rv = 1'b0;
            end else if (rq) begin
                m_rv = 1'b1; m_rs = m_sw; m_re = m_er;
            end
            case (m_st)
                2'd0: if (e) m_st = 2'd1;
                2'd1: if (e) begin m_pa = a; m_pb = b; m_st = 2'd2; end else m_st = 2'd0;
                2'd2: if (!e) m_st = 2'd0;
                      else begin
                          if (a == m_pb && b == m_pa) begin
                              if (m_sw != 16'hFFFF) m_sw = m_sw + 16'd1;
                          end else begin
                              if (m_er != 8'hFF) m_er = m_er + 8'd1;
                              m_fl = 1'b1;
                              if (m_er >= 8'd4) m_st = 2'd3;
                          end
                          m_pa = a; m_pb = b;
                      end
                default: ;
            endcase
        end
        sbq.push_back('{st: m_st, sw: m_sw, er: m_er, fl: m_fl, fa: (m_st == 2'd3),
                        rv: m_rv, rs: m_rs, re: m_re});
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; model_reset(); sbq.delete();
        @(posedge clk); #1;
        tests++;
        if (obs !== '0) begin fails++; $display("FAIL reset got %h exp 0", obs); end
        rst = 1'b0;
    endtask

    task automatic test_alternate();
        ph = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, ph, ~ph, 1'b0, 1'b0, 1'b0); ph = ~ph;
            exp_s = sbq.pop_front(); tests++;
            if (obs !== exp_s) begin fails++; $display("FAIL alt[%0d] got %h exp %h", i, obs, exp_s); end
        end
        tests++;
        if (swap_cnt !== 16'd10 || err_cnt !== 8'd0 || err_flag !== 1'b0 || state_o !== 2'd2) begin
            fails++;
            $display("FAIL alt_final got sw=%0d er=%0d fl=%b st=%0d exp 10 0 0 2",
                     swap_cnt, err_cnt, err_flag, state_o);
        end
    endtask

    task automatic test_mismatch();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            exp_s = sbq.pop_front(); tests++;
            if (obs !== exp_s) begin fails++; $display("FAIL mis[%0d] got %h exp %h", i, obs, exp_s); end
        end
        tests++;
        if (swap_cnt !== 16'd11 || err_cnt !== 8'd1 || err_flag !== 1'b1 || state_o !== 2'd2) begin
            fails++;
            $display("FAIL mis_hold got sw=%0d er=%0d fl=%b st=%0d exp 11 1 1 2",
                     swap_cnt, err_cnt, err_flag, state_o);
        end
        ph = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ph, ~ph, 1'b0, 1'b0, 1'b0); ph = ~ph;
            exp_s = sbq.pop_front(); tests++;
            if (obs !== exp_s) begin fails++; $display("FAIL resume[%0d] got %h exp %h", i, obs, exp_s); end
        end
        tests++;
        if (swap_cnt !== 16'd14) begin fails++; $display("FAIL resume_cnt got %0d exp 14", swap_cnt); end
    endtask

    task automatic test_equal_pair();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_s = sbq.pop_front(); tests++;
        if (obs !== exp_s) begin fails++; $display("FAIL eq_clr got %h exp %h", obs, exp_s); end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            exp_s = sbq.pop_front(); tests++;
            if (obs !== exp_s) begin fails++; $display("FAIL eq[%0d] got %h exp %h", i, obs, exp_s); end
        end
        tests++;
        if (swap_cnt !== 16'd3 || err_cnt !== 8'd0) begin
            fails++; $display("FAIL eq_final got sw=%0d er=%0d exp 3 0", swap_cnt, err_cnt);
        end
    endtask

    task automatic test_report();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        void'(sbq.pop_front());
        ph = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, ph, ~ph, 1'b0, 1'b0, 1'b0); ph = ~ph;
            void'(sbq.pop_front());
        end
        tests++;
        if (swap_cnt !== 16'd5) begin fails++; $display("FAIL rpt_pre got %0d exp 5", swap_cnt); end
        // request, then keep requesting while valid: snapshot must stay at 5
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ph, ~ph, 1'b0, 1'b1, 1'b0); ph = ~ph;
            exp_s = sbq.pop_front(); tests++;
            if (obs !== exp_s || rpt_valid !== 1'b1 || rpt_swap !== 16'd5) begin
                fails++; $display("FAIL rpt_hold[%0d] got %h exp %h (rpt_swap 5)", i, obs, exp_s);
            end
        end
        // ack with req still high: valid drops, req on the ack edge ignored
        drive(1'b1, ph, ~ph, 1'b0, 1'b1, 1'b1); ph = ~ph;
        exp_s = sbq.pop_front(); tests++;
        if (obs !== exp_s || rpt_valid !== 1'b0) begin
            fails++; $display("FAIL rpt_ack got %h exp %h (valid 0)", obs, exp_s);
        end
        drive(1'b1, ph, ~ph, 1'b0, 1'b1, 1'b0); ph = ~ph;
        exp_s = sbq.pop_front(); tests++;
        if (obs !== exp_s || rpt_valid !== 1'b1 || rpt_swap !== 16'd9) begin
            fails++; $display("FAIL rpt_second got %h exp %h (rpt_swap 9)", obs, exp_s);
        end
        drive(1'b1, ph, ~ph, 1'b0, 1'b0, 1'b1); ph = ~ph;
        void'(sbq.pop_front());
    endtask

    task automatic test_threshold();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        void'(sbq.pop_front());
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            exp_s = sbq.pop_front(); tests++;
            if (obs !== exp_s) begin fails++; $display("FAIL thr[%0d] got %h exp %h", i, obs, exp_s); end
        end
        tests++;
        if (state_o !== 2'd3 || fail !== 1'b1 || err_cnt !== 8'd4) begin
            fails++; $display("FAIL thr_fail got st=%0d fail=%b er=%0d exp 3 1 4", state_o, fail, err_cnt);
        end
        ph = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(i[0], ph, i[1], 1'b0, (i == 1), 1'b0); ph = ~ph;
            exp_s = sbq.pop_front(); tests++;
            if (obs !== exp_s) begin fails++; $display("FAIL frozen[%0d] got %h exp %h", i, obs, exp_s); end
        end
        tests++;
        if (rpt_valid !== 1'b1 || rpt_err !== 8'd4) begin
            fails++; $display("FAIL fail_rpt got v=%b err=%0d exp 1 4", rpt_valid, rpt_err);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        void'(sbq.pop_front());
        tests++;
        if (obs !== '0) begin fails++; $display("FAIL thr_clr got %h exp 0", obs); end
    endtask

    task automatic test_saturate();
        int q4[$];
        int e4;
        ph = 1'b1;
        for (int i = 1; i <= 22; i++) begin
            q4.push_back((i < 3) ? 0 : ((i - 2 > 15) ? 15 : i - 2));
            en4 = 1'b1; a4 = ph; b4 = ~ph; ph = ~ph;
            @(posedge clk); #1;
            e4 = q4.pop_front(); tests++;
            if (swap4 !== e4[3:0]) begin fails++; $display("FAIL sat[%0d] got %0d exp %0d", i, swap4, e4); end
        end
        en4 = 1'b0;
    endtask

    task automatic test_async_reset();
        ph = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, ph, ~ph, 1'b0, 1'b0, 1'b0); ph = ~ph;
            void'(sbq.pop_front());
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (obs !== '0) begin fails++; $display("FAIL async_rst got %h exp 0", obs); end
        rst = 1'b0; model_reset();
        ph = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ph, ~ph, 1'b0, 1'b0, 1'b0); ph = ~ph;
            exp_s = sbq.pop_front(); tests++;
            if (obs !== exp_s) begin fails++; $display("FAIL restart[%0d] got %h exp %h", i, obs, exp_s); end
        end
        tests++;
        if (swap_cnt !== 16'd2 || state_o !== 2'd2) begin
            fails++; $display("FAIL restart_cnt got sw=%0d st=%0d exp 2 2", swap_cnt, state_o);
        end
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_mismatch();
        test_equal_pair();
        test_report();
        test_threshold();
        test_saturate();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
